ndp_result_drain: RTL and testbench
===================================

Name: ndp_result_drain

Overview:
Drains the wide accumulated result of the NDP core back toward the memory side. It is the output-direction counterpart of the 32-bit data_in feed path.
- Watches the core's calc_done_flag for a fresh 0->1 transition and snapshots out_c into a local shift register.
- Streams the snapshot as OUT_WIDTH-bit words over a valid/ready handshake.
- Pulses drain_done when the last word is accepted.

Parameters:
WIDTH, 16, bits per result element (matches NDP core).
ARR_WIDTH, 4, PE columns per systolic array.
ARR_HEIGHT, 4, PE rows per systolic array.
SYS_WIDTH, 64, systolic arrays horizontally.
SYS_HEIGHT, 1, systolic arrays vertically.
OUT_WIDTH, 32, output word width; must be a multiple of WIDTH and divide TOTAL_BITS.
TOTAL_BITS (localparam), ARR_WIDTH*SYS_WIDTH*ARR_HEIGHT*SYS_HEIGHT*WIDTH, result vector width (16384 at defaults).
NUM_WORDS (localparam), TOTAL_BITS/OUT_WIDTH, words per drain (512 at defaults).
CNT_BITS (localparam), $clog2(NUM_WORDS+1), word counter width.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset (asserted when 0).
calc_done_flag  in  1  result-ready level from the NDP core.
out_c  in  TOTAL_BITS  result vector from the NDP core; stable while calc_done_flag=1.
data_out_flag  out  1  data_out holds a valid word.
data_out  out  OUT_WIDTH  current result word.
data_out_ready  in  1  consumer accepts the word this cycle.
data_out_last  out  1  asserted with the final word (index NUM_WORDS-1).
drain_busy  out  1  high from capture until the last word is accepted.
drain_done  out  1  one-cycle pulse after the last accept.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, all outputs 0, counter 0, shift register 0.
  - done_prev=1, so a flag already high across reset never triggers a drain.
- Edge detect: done_prev<=calc_done_flag every cycle. A capture requires calc_done_flag=1 and done_prev=0.
- States: IDLE -> SEND -> DONE -> IDLE.
- IDLE, on capture:
  - shreg<=out_c, cnt<=0, data_out_flag<=1, drain_busy<=1, state<=SEND.
  - First word is visible in the cycle after the capture edge (latency 1).
- SEND:
  - data_out = shreg[OUT_WIDTH-1:0], a combinational view of the register.
  - Word k = out_c[k*OUT_WIDTH +: OUT_WIDTH], sent in ascending k.
  - data_out_last = (cnt==NUM_WORDS-1) && data_out_flag.
- Handshake:
  - Transfer occurs when data_out_flag && data_out_ready at a clock edge.
  - On transfer: shreg shifts right by OUT_WIDTH (zero fill) and cnt increments.
  - Without a transfer, data_out and data_out_last hold stable.
  - data_out_flag never drops before the transfer completes.
  - Full throughput: one word per cycle while ready is held high.
- Last transfer (cnt==NUM_WORDS-1):
  - data_out_flag<=0, drain_busy<=0, drain_done<=1, state<=DONE.
- DONE: drain_done<=0, state<=IDLE. drain_done is exactly one cycle wide.
- A rising edge of calc_done_flag during SEND or DONE is ignored and not queued. done_prev still tracks the input.
- If out_c changes during SEND, the transmitted data is unaffected because it comes from the snapshot.
- If data_out_ready is high while data_out_flag=0, nothing happens.
- Reset mid-drain aborts immediately: all outputs return to their reset values and the partial stream is dropped.

Decomposition:
- Shared package ndp_pkg holds:
  - default array geometry (WIDTH, ARR_*, SYS_*);
  - OUT_WIDTH=32;
  - state encoding localparams IDLE=2'd0, SEND=2'd1, DONE=2'd2.
- Single flat module; no sub-module is warranted. The edge detector is one register.

Test Plan:
1. Config SYS_WIDTH=2 (TOTAL_BITS=512, NUM_WORDS=16), out_c word k = 32'hA000_0000+k, ready tied 1. Raise calc_done_flag at cycle 10.
   -> data_out_flag from cycle 11 through 26; words 0xA0000000..0xA000000F in order; last only with 0xA000000F; drain_done pulse at cycle 27.
2. Same data, ready toggling 1,0,0,1 repeating.
   -> 16 words, no duplicates or drops; data_out stable on every stalled cycle; drain_busy high throughout.
3. calc_done_flag held high through and after reset release.
   -> no capture, data_out_flag stays 0. Drop the flag, raise it again -> a normal 16-word drain.
4. Change out_c to all-ones after word 3 is accepted.
   -> words 4..15 still carry the original 0xA0000004..0xA000000F.
5. Pulse calc_done_flag low then high during SEND.
   -> ignored; exactly 16 words and one drain_done pulse.
6. Assert reset (0) after 5 accepted words.
   -> next cycle all outputs 0, state IDLE. A later fresh edge restarts at word 0.

Source files
------------

// File: rtl/ndp_pkg.sv
// Shared NDP definitions: default array geometry, output word width and
// result-drain state encoding.
package ndp_pkg;

    localparam int NDP_WIDTH      = 16;
    localparam int NDP_ARR_WIDTH  = 4;
    localparam int NDP_ARR_HEIGHT = 4;
    localparam int NDP_SYS_WIDTH  = 64;
    localparam int NDP_SYS_HEIGHT = 1;
    localparam int NDP_OUT_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } drain_state_e;

endpackage

// File: rtl/ndp_result_drain.sv
// Snapshots the NDP core result on a fresh calc_done_flag rise and streams it
// out LSB-word first over a valid/ready handshake.
module ndp_result_drain
    import ndp_pkg::*;
#(
    parameter int WIDTH      = NDP_WIDTH,
    parameter int ARR_WIDTH  = NDP_ARR_WIDTH,
    parameter int ARR_HEIGHT = NDP_ARR_HEIGHT,
    parameter int SYS_WIDTH  = NDP_SYS_WIDTH,
    parameter int SYS_HEIGHT = NDP_SYS_HEIGHT,
    parameter int OUT_WIDTH  = NDP_OUT_WIDTH,
    localparam int TOTAL_BITS = ARR_WIDTH * SYS_WIDTH * ARR_HEIGHT * SYS_HEIGHT * WIDTH,
    localparam int NUM_WORDS  = TOTAL_BITS / OUT_WIDTH,
    localparam int CNT_BITS   = $clog2(NUM_WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  calc_done_flag,
    input  logic [TOTAL_BITS-1:0] out_c,
    output logic                  data_out_flag,
    output logic [OUT_WIDTH-1:0]  data_out,
    input  logic                  data_out_ready,
    output logic                  data_out_last,
    output logic                  drain_busy,
    output logic                  drain_done
);

    drain_state_e          state, state_d;
    logic [TOTAL_BITS-1:0] shreg, shreg_d;
    logic [CNT_BITS-1:0]   cnt, cnt_d;
    logic                  done_prev;
    logic                  flag_d, busy_d, done_d;
    logic                  capture, xfer, at_last;

    assign capture       = calc_done_flag && !done_prev;
    assign xfer          = data_out_flag && data_out_ready;
    assign at_last       = (cnt == CNT_BITS'(NUM_WORDS - 1));
    assign data_out      = shreg[OUT_WIDTH-1:0];
    assign data_out_last = at_last && data_out_flag;

    always_comb begin
        state_d = state;
        shreg_d = shreg;
        cnt_d   = cnt;
        flag_d  = data_out_flag;
        busy_d  = drain_busy;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    shreg_d = out_c;
                    cnt_d   = '0;
                    flag_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    shreg_d = shreg >> OUT_WIDTH;
                    cnt_d   = cnt + CNT_BITS'(1);
                    if (at_last) begin
                        flag_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // done_prev resets high so a flag already asserted across reset is not an edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            shreg         <= '0;
            cnt           <= '0;
            done_prev     <= 1'b1;
            data_out_flag <= 1'b0;
            drain_busy    <= 1'b0;
            drain_done    <= 1'b0;
        end else begin
            state         <= state_d;
            shreg         <= shreg_d;
            cnt           <= cnt_d;
            done_prev     <= calc_done_flag;
            data_out_flag <= flag_d;
            drain_busy    <= busy_d;
            drain_done    <= done_d;
        end
    end

endmodule

// File: tb/tb_ndp_result_drain.sv
// Directed bench for ndp_result_drain with a 16-word geometry (SYS_WIDTH=2).
module tb_ndp_result_drain;

    localparam int TB_BITS  = 512;
    localparam int TB_WORDS = 16;

    typedef struct {
        logic        ready;
        logic        flag;
        logic [31:0] data;
        logic        last;
        logic        busy;
        logic        done;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               calc_done_flag;
    logic [TB_BITS-1:0] out_c;
    logic               data_out_flag;
    logic [31:0]        data_out;
    logic               data_out_ready;
    logic               data_out_last;
    logic               drain_busy;
    logic               drain_done;

    int total = 0;
    int bad   = 0;

    ndp_result_drain #(.SYS_WIDTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .calc_done_flag (calc_done_flag),
        .out_c          (out_c),
        .data_out_flag  (data_out_flag),
        .data_out       (data_out),
        .data_out_ready (data_out_ready),
        .data_out_last  (data_out_last),
        .drain_busy     (drain_busy),
        .drain_done     (drain_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        check({tag, " flag"}, 32'(data_out_flag), 32'(v.flag));
        check({tag, " data"}, data_out, v.data);
        check({tag, " last"}, 32'(data_out_last), 32'(v.last));
        check({tag, " busy"}, 32'(drain_busy), 32'(v.busy));
        check({tag, " done"}, 32'(drain_done), 32'(v.done));
    endtask

    task automatic load_pattern();
        for (int k = 0; k < TB_WORDS; k++) out_c[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    endtask

    // Flag low for one edge, then high: the rising edge is captured on the next edge.
    task automatic start_drain();
        calc_done_flag = 1'b0;
        tick();
        calc_done_flag = 1'b1;
        tick();
    endtask

    // Expected stream for a ready pattern (period 4), followed by the done pulse and idle.
    function automatic void build(output vec_t q[$], input logic [3:0] pat);
        int   k = 0;
        int   i = 0;
        vec_t v;
        q = {};
        while (k < TB_WORDS) begin
            v.ready = pat[i % 4];
            v.flag  = 1'b1;
            v.data  = 32'hA000_0000 + 32'(k);
            v.last  = (k == TB_WORDS - 1);
            v.busy  = 1'b1;
            v.done  = 1'b0;
            q.push_back(v);
            if (v.ready) k++;
            i++;
        end
        v = '{ready: 1'b1, flag: 1'b0, data: 32'h0, last: 1'b0, busy: 1'b0, done: 1'b1};
        q.push_back(v);
        v.done = 1'b0;
        q.push_back(v);
    endfunction

    task automatic run_table(input string tag, input vec_t q[$]);
        for (int i = 0; i < q.size(); i++) begin
            check_outs($sformatf("%s[%0d]", tag, i), q[i]);
            data_out_ready = q[i].ready;
            tick();
        end
    endtask

    initial begin
        vec_t tbl_full[$];
        vec_t tbl_stall[$];
        vec_t zero_v;
        int   dones;
        build(tbl_full, 4'b1111);
        build(tbl_stall, 4'b1001);  // ready 1,0,0,1 repeating (bit i = cycle i)
        zero_v = '{ready: 1'b0, flag: 1'b0, data: 32'h0, last: 1'b0, busy: 1'b0, done: 1'b0};

        // Flag held high through reset release must not start a drain
        reset = 1'b0;
        calc_done_flag = 1'b1;
        data_out_ready = 1'b1;
        out_c = '0;
        load_pattern();
        repeat (3) tick();
        check_outs("reset", zero_v);
        reset = 1'b1;
        repeat (4) tick();
        check_outs("flag_held", zero_v);

        // Full throughput, then stalled handshake
        start_drain();
        run_table("full", tbl_full);
        start_drain();
        run_table("stall", tbl_stall);

        // Snapshot isolation: out_c overwritten after word 3 accepted
        start_drain();
        data_out_ready = 1'b1;
        for (int k = 0; k < TB_WORDS; k++) begin
            check($sformatf("snap w%0d", k), data_out, 32'hA000_0000 + 32'(k));
            tick();
            if (k == 3) out_c = '1;
        end
        check("snap done", 32'(drain_done), 32'd1);
        tick();
        load_pattern();

        // Re-edge of calc_done_flag during SEND is ignored
        start_drain();
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 4) calc_done_flag = 1'b0;
            if (c == 6) calc_done_flag = 1'b1;
            if (c < TB_WORDS)
                check($sformatf("reedge w%0d", c), data_out, 32'hA000_0000 + 32'(c));
            if (drain_done) dones++;
            tick();
        end
        check("reedge done count", 32'(dones), 32'd1);
        check("reedge idle flag", 32'(data_out_flag), 32'd0);

        // Reset mid-drain aborts; a fresh edge restarts at word 0
        start_drain();
        repeat (5) tick();
        check("pre-abort w5", data_out, 32'hA000_0005);
        reset = 1'b0;
        tick();
        check_outs("abort", zero_v);
        reset = 1'b1;
        tick();
        check("post-abort idle", 32'(data_out_flag), 32'd0);
        start_drain();
        run_table("restart", tbl_full);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
